// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: Moore FSM sequencing a shared memory/ALU datapath,
// plus the architectural NZCV register and conditional-execution gating.
module arm_multicycle_ctrl #(
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cond,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [3:0]            alu_flags,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_w,
  output logic                  ir_write,
  output logic                  reg_w,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            flags_q,
  output logic [3:0]            state_q
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [ALU_CTRL_W-1:0] OP_ADD = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] OP_SUB = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] OP_AND = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] OP_ORR = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] OP_EOR = ALU_CTRL_W'(4);

  logic [3:0]            state_d;
  logic                  cond_ex, cond_ex_q, cond_ok;
  logic [ALU_CTRL_W-1:0] alu_op;
  logic [1:0]            flag_w;
  logic                  is_cmp;
  logic                  fetch_pc, branch, reg_w_raw, mem_w_raw, ir_write_raw;
  logic                  in_exec;
  logic                  fn, fz, fc, fv;

  assign {fn, fz, fc, fv} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = fz;
      4'b0001: cond_ex = ~fz;
      4'b0010: cond_ex = fc;
      4'b0011: cond_ex = ~fc;
      4'b0100: cond_ex = fn;
      4'b0101: cond_ex = ~fn;
      4'b0110: cond_ex = fv;
      4'b0111: cond_ex = ~fv;
      4'b1000: cond_ex = fc & ~fz;
      4'b1001: cond_ex = ~fc | fz;
      4'b1010: cond_ex = (fn == fv);
      4'b1011: cond_ex = (fn != fv);
      4'b1100: cond_ex = ~fz & (fn == fv);
      4'b1101: cond_ex = fz | (fn != fv);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // EOR and CMP decode only exist in the extended ALU; otherwise they fall to ADD.
  always_comb begin
    alu_op = OP_ADD;
    flag_w = 2'b00;
    is_cmp = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_op = OP_ADD; flag_w = {2{funct[0]}}; end
      4'b0010: begin alu_op = OP_SUB; flag_w = {2{funct[0]}}; end
      4'b0000: begin alu_op = OP_AND; flag_w = {funct[0], 1'b0}; end
      4'b1100: begin alu_op = OP_ORR; flag_w = {funct[0], 1'b0}; end
      4'b0001: if (ALU_CTRL_W == 3) begin alu_op = OP_EOR; flag_w = {funct[0], 1'b0}; end
      4'b1010: if (ALU_CTRL_W == 3) begin alu_op = OP_SUB; flag_w = 2'b11; is_cmp = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: case (op)
                  2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                  2'b01:   state_d = S_MEMADR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
                endcase
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src      = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    alu_control  = OP_ADD;
    fetch_pc     = 1'b0;
    branch       = 1'b0;
    reg_w_raw    = 1'b0;
    mem_w_raw    = 1'b0;
    ir_write_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        fetch_pc     = 1'b1;
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
      end
      S_DECODE: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_MEMADR: alu_src_b = 2'b01;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w_raw  = 1'b1;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_w_raw = 1'b1;
      end
      S_EXECR: alu_control = alu_op;
      S_EXECI: begin
        alu_src_b   = 2'b01;
        alu_control = alu_op;
      end
      S_ALUWB: reg_w_raw = ~is_cmp;
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // Writeback in ALUWB must see the condition evaluated on the pre-update flags.
  assign cond_ok  = (state_q == S_ALUWB) ? cond_ex_q : cond_ex;
  assign in_exec  = (state_q == S_EXECR) || (state_q == S_EXECI);

  assign ir_write = rst_n & ir_write_raw;
  assign reg_w    = rst_n & reg_w_raw & cond_ok;
  assign mem_w    = rst_n & mem_w_raw & cond_ok;
  assign pc_write = rst_n & (fetch_pc | (branch & cond_ok) |
                             (reg_w_raw & (rd == 4'd15) & cond_ok));
  assign imm_src  = op;
  assign reg_src  = {op == 2'b01, op == 2'b10};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_exec) begin
        cond_ex_q <= cond_ex;
        if (cond_ex && flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
        if (cond_ex && flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench: drives the 2-bit and 3-bit ALU-control variants side by side
// against an instruction-level reference model.
module tb_arm_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] strb;   // {pc_write, adr_src, mem_w, ir_write, reg_w}
    logic [5:0] mux;    // {alu_src_a, alu_src_b, result_src}
    logic [2:0] alu;
    logic [3:0] flg;
    logic [3:0] src;    // {imm_src, reg_src}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cond = '0;
  logic [1:0] op = '0;
  logic [5:0] funct = '0;
  logic [3:0] rd = '0;
  logic [3:0] alu_flags = '0;

  logic       pw2, as2, mw2, iw2, rw2, pw3, as3, mw3, iw3, rw3;
  logic [1:0] sa2, sb2, rs2, is2, rg2, sa3, sb3, rs3, is3, rg3;
  logic [1:0] ac2;
  logic [2:0] ac3;
  logic [3:0] fq2, sq2, fq3, sq3;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q2[$];
  exp_t q3[$];
  exp_t e2, e3;
  logic [3:0] mflags [2];

  arm_multicycle_ctrl #(.ALU_CTRL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_write(pw2), .adr_src(as2), .mem_w(mw2),
    .ir_write(iw2), .reg_w(rw2), .alu_src_a(sa2), .alu_src_b(sb2),
    .result_src(rs2), .imm_src(is2), .reg_src(rg2), .alu_control(ac2),
    .flags_q(fq2), .state_q(sq2));

  arm_multicycle_ctrl #(.ALU_CTRL_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .pc_write(pw3), .adr_src(as3), .mem_w(mw3),
    .ir_write(iw3), .reg_w(rw3), .alu_src_a(sa3), .alu_src_b(sb3),
    .result_src(rs3), .imm_src(is3), .reg_src(rg3), .alu_control(ac3),
    .flags_q(fq3), .state_q(sq3));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic cond_fn(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? ~base : base;
  endfunction

  // Returns {alu_control[2:0], flag_w[1:0], is_cmp}
  function automatic logic [5:0] mdec(input bit w3, input logic [5:0] f);
    logic s;
    s = f[0];
    case (f[4:1])
      4'b0100: return {3'd0, s, s, 1'b0};
      4'b0010: return {3'd1, s, s, 1'b0};
      4'b0000: return {3'd2, s, 1'b0, 1'b0};
      4'b1100: return {3'd3, s, 1'b0, 1'b0};
      4'b0001: return w3 ? {3'd4, s, 1'b0, 1'b0} : 6'd0;
      4'b1010: return w3 ? {3'd1, 1'b1, 1'b1, 1'b1} : 6'd0;
      default: return 6'd0;
    endcase
  endfunction

  function automatic logic [3:0] mnext(input logic [3:0] ms, input logic [1:0] o,
                                       input logic [5:0] f);
    case (ms)
      4'd0: return 4'd1;
      4'd1: return (o == 2'b01) ? 4'd2 : (o == 2'b10) ? 4'd9 :
                   (o == 2'b11) ? 4'd0 : (f[5] ? 4'd7 : 4'd6);
      4'd2: return f[0] ? 4'd3 : 4'd5;
      4'd3: return 4'd4;
      4'd6, 4'd7: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic exp_t mexp(input int k, input logic [3:0] ms, input logic ok);
    exp_t e;
    logic [5:0] d;
    logic w;
    d = mdec(k == 1, funct);
    e = '0;
    e.st  = ms;
    e.flg = mflags[k];
    e.src = {op, op == 2'b01, op == 2'b10};
    case (ms)
      4'd0: begin e.strb = 5'b10010; e.mux = 6'b011010; end
      4'd1: e.mux = 6'b011010;
      4'd2: e.mux = 6'b000100;
      4'd3: e.strb = 5'b01000;
      4'd4: begin e.strb = {ok && rd == 4'd15, 3'b000, ok}; e.mux = 6'b000001; end
      4'd5: e.strb = {2'b01, ok, 2'b00};
      4'd6: e.alu = d[5:3];
      4'd7: begin e.mux = 6'b000100; e.alu = d[5:3]; end
      4'd8: begin w = ok & ~d[0]; e.strb = {w && rd == 4'd15, 3'b000, w}; end
      4'd9: begin e.strb = {ok, 4'b0000}; e.mux = 6'b100110; end
      default: ;
    endcase
    return e;
  endfunction

  // Called at posedge+1 with the DUTs in FETCH; returns with them back in FETCH.
  task automatic run(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input logic [3:0] af);
    logic [3:0] ms;
    logic       ok [2];
    logic [5:0] d;
    cond = c; op = o; funct = f; rd = r; alu_flags = af;
    for (int k = 0; k < 2; k++) ok[k] = cond_fn(c, mflags[k]);
    ms = 4'd0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      q2.push_back(mexp(0, ms, ok[0]));
      q3.push_back(mexp(1, ms, ok[1]));
      if (ms == 4'd6 || ms == 4'd7) begin
        for (int k = 0; k < 2; k++) begin
          d = mdec(k == 1, f);
          if (ok[k] && d[2]) mflags[k][3:2] = af[3:2];
          if (ok[k] && d[1]) mflags[k][1:0] = af[1:0];
        end
      end
      ms = mnext(ms, o, f);
      @(posedge clk); #1;
      if (ms == 4'd0) break;
    end
  endtask

  always @(negedge clk) begin
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      chk("w2 state",  32'(sq2), 32'(e2.st));
      chk("w2 strobe", 32'({pw2, as2, mw2, iw2, rw2}), 32'(e2.strb));
      chk("w2 mux",    32'({sa2, sb2, rs2}), 32'(e2.mux));
      chk("w2 aluctl", 32'(ac2), 32'(e2.alu));
      chk("w2 flags",  32'(fq2), 32'(e2.flg));
      chk("w2 src",    32'({is2, rg2}), 32'(e2.src));
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      chk("w3 state",  32'(sq3), 32'(e3.st));
      chk("w3 strobe", 32'({pw3, as3, mw3, iw3, rw3}), 32'(e3.strb));
      chk("w3 mux",    32'({sa3, sb3, rs3}), 32'(e3.mux));
      chk("w3 aluctl", 32'(ac3), 32'(e3.alu));
      chk("w3 flags",  32'(fq3), 32'(e3.flg));
      chk("w3 src",    32'({is3, rg3}), 32'(e3.src));
    end
  end

  initial begin
    mflags[0] = 4'b0000;
    mflags[1] = 4'b0000;
    #1 rst_n = 1'b0;
    #2;
    chk("rst strobes w2", 32'({pw2, iw2, rw2, mw2}), 32'd0);
    chk("rst strobes w3", 32'({pw3, iw3, rw3, mw3}), 32'd0);
    chk("rst state", 32'({sq2, sq3}), 32'd0);
    chk("rst flags", 32'({fq2, fq3}), 32'd0);
    chk("rst mux fetch", 32'({sa3, sb3, rs3}), 32'(6'b011010));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(4'b1110, 2'b00, 6'b101000, 4'd1, 4'b1111);   // ADD R1,R2,#5
    run(4'b1110, 2'b00, 6'b000101, 4'd1, 4'b0100);   // SUBS -> Z
    run(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BEQ taken
    run(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0000);   // ADDS -> 0000
    run(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);   // BEQ not taken
    run(4'b1110, 2'b00, 6'b000101, 4'd2, 4'b0110);   // SUBS -> 0110
    run(4'b1110, 2'b00, 6'b000001, 4'd3, 4'b1011);   // ANDS -> 1010
    run(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);  // LDR R15
    run(4'b1110, 2'b01, 6'b011000, 4'd3, 4'b0000);   // STR
    run(4'b1110, 2'b00, 6'b000011, 4'd4, 4'b0101);   // EORS
    run(4'b1110, 2'b00, 6'b010101, 4'd5, 4'b0010);   // CMP
    run(4'b1110, 2'b00, 6'b001001, 4'd0, 4'b0100);   // ADDS -> Z set
    run(4'b0000, 2'b00, 6'b000101, 4'd15, 4'b0000);  // SUBSEQ PC: cond on old Z
    run(4'b1111, 2'b01, 6'b011001, 4'd15, 4'b0000);  // never-LDR, gated
    run(4'b1110, 2'b11, 6'b111111, 4'd15, 4'b1111);  // undefined
    for (int i = 0; i < 40; i++)
      run(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          6'($urandom_range(0, 63)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)));

    run(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b1111);   // ADDS -> 1111
    cond = 4'b1110; op = 2'b01; funct = 6'b011000; rd = 4'd3;
    repeat (3) begin @(posedge clk); #1; end
    chk("memwr state", 32'(sq3), 32'd5);
    chk("memwr mem_w", 32'({mw2, mw3}), 32'(2'b11));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst mem_w", 32'({mw2, mw3}), 32'd0);
    chk("async rst state", 32'({sq2, sq3}), 32'd0);
    chk("async rst flags", 32'({fq2, fq3}), 32'd0);
    chk("async rst pc/ir", 32'({pw2, iw2, pw3, iw3}), 32'd0);
    mflags[0] = 4'b0000;
    mflags[1] = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(4'b1110, 2'b11, 6'b000000, 4'd15, 4'b0000);  // undefined after reset
    run(4'b1110, 2'b00, 6'b101000, 4'd1, 4'b0000);

    @(negedge clk); #1;
    chk("scoreboard drained", 32'(q2.size() + q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
